// File: rtl/secp256k1_pkg.sv
// Shared constants and FSM state type for the secp256k1 on-curve checker.
package secp256k1_pkg;

    localparam int SECP_WIDTH = 256;

    localparam logic [SECP_WIDTH-1:0] SECP_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam logic [SECP_WIDTH-1:0] SECP_B = 256'd7;

    localparam logic [SECP_WIDTH-1:0] SECP_GX =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;

    localparam logic [SECP_WIDTH-1:0] SECP_GY =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_YY  = 3'd1,
        ST_MUL_XX  = 3'd2,
        ST_MUL_XXX = 3'd3,
        ST_FINAL   = 3'd4,
        ST_DONE    = 3'd5
    } checkState_e;

endpackage

// File: rtl/secp256k1_on_curve_check_if.sv
// Point-in / verdict-out handshake bundle between a point producer and the checker.
interface secp256k1_on_curve_check_if
    import secp256k1_pkg::*;
#(
    parameter int WIDTH = SECP_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             out_valid;
    logic             out_ready;
    logic             on_curve;
    logic             out_range_err;

    modport master (
        output in_valid,
        input  in_ready,
        output x_in,
        output y_in,
        input  out_valid,
        output out_ready,
        input  on_curve,
        input  out_range_err
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  x_in,
        input  y_in,
        output out_valid,
        input  out_ready,
        output on_curve,
        output out_range_err
    );

endinterface

// File: rtl/secp256k1_modmul_serial.sv
// MSB-first interleaved modular multiplier: one load cycle, then one bit of b per cycle.
module secp256k1_modmul_serial
    import secp256k1_pkg::*;
#(
    parameter int               WIDTH = SECP_WIDTH,
    parameter logic [WIDTH-1:0] P     = SECP_P
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   dblVal;
    logic [WIDTH:0]   dblRed;
    logic [WIDTH:0]   sumVal;
    logic [WIDTH:0]   sumRed;

    // acc and a stay below P, so 2*acc and dblRed + a both fit in WIDTH+1 bits.
    always_comb begin
        dblVal = {acc_q, 1'b0};
        dblRed = (dblVal >= {1'b0, P}) ? (dblVal - {1'b0, P}) : dblVal;
        sumVal = b_q[WIDTH-1] ? (dblRed + {1'b0, a_q}) : dblRed;
        sumRed = (sumVal >= {1'b0, P}) ? (sumVal - {1'b0, P}) : sumVal;
    end

    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            acc_d  = '0;
            a_d    = a_i;
            b_d    = b_i;
            cnt_d  = CW'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = sumRed[WIDTH-1:0];
            b_d   = {b_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = acc_q;

endmodule

// File: rtl/secp256k1_on_curve_check.sv
// Checks y^2 == x^3 + b (mod P) for an accepted affine point using one shared serial multiplier.
// Optional RANGE_CHECK_EN: flag x or y >= P at accept and answer immediately with out_range_err.
module secp256k1_on_curve_check
    import secp256k1_pkg::*;
#(
    parameter int               WIDTH   = SECP_WIDTH,
    parameter logic [WIDTH-1:0] P       = SECP_P,
    parameter logic [WIDTH-1:0] CURVE_B = SECP_B
) (
    input  logic                       clk,
    input  logic                       reset,
    secp256k1_on_curve_check_if.slave  chk
);

    checkState_e      state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] ySq_q, ySq_d;
    logic             onCurve_q, onCurve_d;

    logic             accept;
    logic             mulStart;
    logic [WIDTH-1:0] mulA;
    logic [WIDTH-1:0] mulB;
    logic             mulBusy;
    logic             mulDone;
    logic             mulFinished;
    logic [WIDTH-1:0] mulResult;
    logic [WIDTH:0]   rhsSum;
    logic [WIDTH:0]   rhsRed;

`ifdef RANGE_CHECK_EN
    logic             rangeErr_q, rangeErr_d;
    logic             rangeBad;

    assign rangeBad = (chk.x_in >= P) || (chk.y_in >= P);
`endif

    assign accept      = chk.in_valid & chk.in_ready;
    assign mulFinished = mulDone & ~mulBusy;

    // The multiplier result holds x^3 while in FINAL, so b is added straight onto it.
    assign rhsSum = {1'b0, mulResult} + {1'b0, CURVE_B};
    assign rhsRed = (rhsSum >= {1'b0, P}) ? (rhsSum - {1'b0, P}) : rhsSum;

    secp256k1_modmul_serial #(
        .WIDTH (WIDTH),
        .P     (P)
    ) u_modmul (
        .clk      (clk),
        .reset    (reset),
        .start_i  (mulStart),
        .a_i      (mulA),
        .b_i      (mulB),
        .busy_o   (mulBusy),
        .done_o   (mulDone),
        .result_o (mulResult)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        ySq_d     = ySq_q;
        onCurve_d = onCurve_q;
        mulStart  = 1'b0;
        mulA      = x_q;
        mulB      = x_q;
`ifdef RANGE_CHECK_EN
        rangeErr_d = rangeErr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    x_d       = chk.x_in;
                    onCurve_d = 1'b0;
`ifdef RANGE_CHECK_EN
                    rangeErr_d = rangeBad;
                    if (rangeBad) begin
                        state_d = ST_DONE;
                    end else begin
                        mulStart = 1'b1;
                        mulA     = chk.y_in;
                        mulB     = chk.y_in;
                        state_d  = ST_MUL_YY;
                    end
`else
                    mulStart = 1'b1;
                    mulA     = chk.y_in;
                    mulB     = chk.y_in;
                    state_d  = ST_MUL_YY;
`endif
                end
            end
            ST_MUL_YY: begin
                if (mulFinished) begin
                    ySq_d    = mulResult;
                    mulStart = 1'b1;
                    state_d  = ST_MUL_XX;
                end
            end
            ST_MUL_XX: begin
                // Chain x^2 directly into the next multiply instead of storing it.
                if (mulFinished) begin
                    mulStart = 1'b1;
                    mulA     = mulResult;
                    state_d  = ST_MUL_XXX;
                end
            end
            ST_MUL_XXX: begin
                if (mulFinished) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                onCurve_d = (rhsRed == {1'b0, ySq_q});
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (chk.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            ySq_q     <= '0;
            onCurve_q <= 1'b0;
`ifdef RANGE_CHECK_EN
            rangeErr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            ySq_q     <= ySq_d;
            onCurve_q <= onCurve_d;
`ifdef RANGE_CHECK_EN
            rangeErr_q <= rangeErr_d;
`endif
        end
    end

    assign chk.in_ready  = (state_q == ST_IDLE) && !reset;
    assign chk.out_valid = (state_q == ST_DONE);
    assign chk.on_curve  = onCurve_q;
`ifdef RANGE_CHECK_EN
    assign chk.out_range_err = rangeErr_q;
`else
    assign chk.out_range_err = 1'b0;
`endif

endmodule
